// File: rtl/char_seq_ctrl_if.sv
// Handshake and pixel bus between the banner sequencer and its driver:
// control pulses, text and pixel coordinates in; renderer selects and status out.
interface char_seq_ctrl_if #(
  parameter int NUM_CHARS = 8
);
  logic                   frame_tick;
  logic                   start;
  logic                   clear;
  logic [4*NUM_CHARS-1:0] text;
  logic [9:0]             x;
  logic [9:0]             y;
  logic [9:0]             start_x;
  logic [9:0]             start_y;
  logic [9:0]             x_o;
  logic [9:0]             y_o;
  logic [3:0]             glyph_sel;
  logic                   pixel_en;
  logic                   busy;
  logic                   done;

  modport master (
    output frame_tick, start, clear, text, x, y,
    input  start_x, start_y, x_o, y_o, glyph_sel, pixel_en, busy, done
  );

  modport slave (
    input  frame_tick, start, clear, text, x, y,
    output start_x, start_y, x_o, y_o, glyph_sel, pixel_en, busy, done
  );
endinterface

// File: rtl/char_seq_ctrl.sv
// Text banner sequencer: decodes each pixel into a character cell and reveals,
// blinks (when CHAR_SEQ_BLINK_EN is defined) and then holds the string.
module char_seq_ctrl #(
  parameter int BASE_X        = 192,
  parameter int BASE_Y        = 220,
  parameter int NUM_CHARS     = 8,
  parameter int REVEAL_FRAMES = 4,
  parameter int BLINK_FRAMES  = 15,
  parameter int BLINK_COUNT   = 3
) (
  input logic            clk,
  input logic            rst_n,
  char_seq_ctrl_if.slave bus
);

  localparam int CELL_W  = 32;
  localparam int GLYPH_W = 26;
  localparam int GLYPH_H = 40;
  localparam int RW      = $clog2(NUM_CHARS + 1);
  localparam int FMAX    = (BLINK_FRAMES > REVEAL_FRAMES && BLINK_COUNT > 0) ?
                           BLINK_FRAMES : REVEAL_FRAMES;
  localparam int FW      = (FMAX > 1) ? $clog2(FMAX) : 1;
`ifdef CHAR_SEQ_BLINK_EN
  localparam int BW      = $clog2(2 * BLINK_COUNT + 1);
`endif

  typedef enum logic [1:0] {IDLE, REVEAL, BLINK, SHOW} state_e;

  state_e                 state_q;
  logic [4*NUM_CHARS-1:0] text_q;
  logic [RW-1:0]          rev_q;
  logic [FW-1:0]          fcnt_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef CHAR_SEQ_BLINK_EN
  logic [BW-1:0]          bcnt_q;
  logic                   blink_on_q;
`endif

  logic [9:0] off_d;
  logic [4:0] idx_d;
  logic       row_hit_d, col_hit_d, in_glyph_d, visible_d;
  logic [3:0] code_d;
  logic       pixel_en_d;
  logic [9:0] start_x_d, start_y_d;

  logic [9:0] start_x_q, start_y_q, x_q, y_q;
  logic [3:0] glyph_sel_q;
  logic       pixel_en_q;

  // Cell decode runs on the state as it stood before this clock edge.
  always_comb begin
    off_d      = bus.x - 10'(BASE_X);
    idx_d      = off_d[9:5];
    row_hit_d  = (bus.y >= 10'(BASE_Y)) && ({1'b0, bus.y} < 11'(BASE_Y + GLYPH_H));
    col_hit_d  = (bus.x >= 10'(BASE_X)) &&
                 ({1'b0, bus.x} < 11'(BASE_X + CELL_W * NUM_CHARS));
    in_glyph_d = off_d[4:0] < 5'(GLYPH_W);
    code_d     = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (idx_d == 5'(i)) code_d = text_q[4*i +: 4];
    end
    case (state_q)
      REVEAL:  visible_d = {1'b0, idx_d} < 6'(rev_q);
`ifdef CHAR_SEQ_BLINK_EN
      BLINK:   visible_d = blink_on_q;
`endif
      SHOW:    visible_d = 1'b1;
      default: visible_d = 1'b0;
    endcase
    pixel_en_d = row_hit_d & col_hit_d & in_glyph_d & visible_d & (code_d != 4'd0);
    start_x_d  = pixel_en_d ? (10'(BASE_X) + {idx_d, 5'b0}) : '0;
    start_y_d  = pixel_en_d ? 10'(BASE_Y) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_en_q  <= 1'b0;
      glyph_sel_q <= '0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      pixel_en_q  <= pixel_en_d;
      glyph_sel_q <= pixel_en_d ? code_d : 4'd0;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      x_q         <= bus.x;
      y_q         <= bus.y;
    end
  end

  // Clear beats start, and start beats a coincident frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      text_q     <= '0;
      rev_q      <= '0;
      fcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CHAR_SEQ_BLINK_EN
      bcnt_q     <= '0;
      blink_on_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (bus.start) begin
        text_q  <= bus.text;
        rev_q   <= '0;
        fcnt_q  <= '0;
        state_q <= REVEAL;
        busy_q  <= 1'b1;
      end else if (bus.frame_tick) begin
        case (state_q)
          REVEAL: begin
            if (fcnt_q == FW'(REVEAL_FRAMES - 1)) begin
              fcnt_q <= '0;
              rev_q  <= rev_q + 1'b1;
              if (rev_q == RW'(NUM_CHARS - 1)) begin
`ifdef CHAR_SEQ_BLINK_EN
                state_q    <= BLINK;
                blink_on_q <= 1'b1;
                bcnt_q     <= '0;
`else
                state_q <= SHOW;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
`ifdef CHAR_SEQ_BLINK_EN
          BLINK: begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
              fcnt_q     <= '0;
              blink_on_q <= ~blink_on_q;
              bcnt_q     <= bcnt_q + 1'b1;
              if (bcnt_q == BW'(2 * BLINK_COUNT - 1)) begin
                state_q <= SHOW;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.pixel_en  = pixel_en_q;
  assign bus.glyph_sel = glyph_sel_q;
  assign bus.start_x   = start_x_q;
  assign bus.start_y   = start_y_q;
  assign bus.x_o       = x_q;
  assign bus.y_o       = y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_char_seq_ctrl.sv
// Self-checking bench for char_seq_ctrl: reveal, blink or no-blink ending,
// cell boundaries, command priority and mid-run reset.
module tb_char_seq_ctrl;

  localparam int NC = 8;
  localparam int BX = 192;
  localparam int BY = 220;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  char_seq_ctrl_if #(.NUM_CHARS(NC)) bus ();

  char_seq_ctrl #(
    .BASE_X(BX), .BASE_Y(BY), .NUM_CHARS(NC),
    .REVEAL_FRAMES(4), .BLINK_FRAMES(15), .BLINK_COUNT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       en;
    logic [3:0] g;
  } pix_t;

  pix_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] curText = '0;

  // Expected renderer outputs, from the first `shown` slots being visible.
  function automatic pix_t model(input logic [9:0] px, input logic [9:0] py, input int shown);
    pix_t e;
    int lo;
    logic [3:0] c;
    e.x = px; e.y = py; e.en = 1'b0; e.g = 4'd0; e.sx = '0; e.sy = '0;
    for (int i = 0; i < NC; i++) begin
      lo = BX + 32 * i;
      c  = curText[4*i +: 4];
      if (int'(px) >= lo && int'(px) < lo + 26 && int'(py) >= BY && int'(py) < BY + 40 &&
          i < shown && c != 4'd0) begin
        e.en = 1'b1; e.g = c; e.sx = 10'(lo); e.sy = 10'(BY);
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] t, input bit withTick, input bit withClear);
    bus.text = t; bus.start = 1'b1; bus.frame_tick = withTick; bus.clear = withClear;
    if (!withClear) curText = t;
    @(negedge clk);
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic pulseTick();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic checkPix(input string name, input logic [9:0] px, input logic [9:0] py, input int shown);
    pix_t e;
    bus.x = px; bus.y = py;
    sb.push_back(model(px, py, shown));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.pixel_en !== e.en) begin
      errors++; $display("[TB] FAIL %s pixel_en got %0b want %0b", name, bus.pixel_en, e.en);
    end
    checks++;
    if (bus.glyph_sel !== e.g) begin
      errors++; $display("[TB] FAIL %s glyph_sel got %0d want %0d", name, bus.glyph_sel, e.g);
    end
    checks++;
    if (bus.x_o !== e.x || bus.y_o !== e.y) begin
      errors++; $display("[TB] FAIL %s x_o/y_o got %0d/%0d want %0d/%0d", name, bus.x_o, bus.y_o, e.x, e.y);
    end
    if (e.en) begin
      checks++;
      if (bus.start_x !== e.sx || bus.start_y !== e.sy) begin
        errors++; $display("[TB] FAIL %s start_x/start_y got %0d/%0d want %0d/%0d",
                           name, bus.start_x, bus.start_y, e.sx, e.sy);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic expBusy, input logic expDone);
    checks++;
    if (bus.busy !== expBusy || bus.done !== expDone) begin
      errors++; $display("[TB] FAIL %s busy/done got %0b/%0b want %0b/%0b", name, bus.busy, bus.done, expBusy, expDone);
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if (bus.pixel_en !== 1'b0 || bus.glyph_sel !== 4'd0 || bus.start_x !== 10'd0 || bus.start_y !== 10'd0 ||
        bus.x_o !== 10'd0 || bus.y_o !== 10'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s outputs got en=%0b g=%0d sx=%0d sy=%0d xo=%0d yo=%0d busy=%0b done=%0b want all 0",
               name, bus.pixel_en, bus.glyph_sel, bus.start_x, bus.start_y, bus.x_o, bus.y_o, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.x = 10'd259; bus.y = 10'd230;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_reveal();
    applyStimulus(32'h8765_0321, 1'b0, 1'b0);
    checkOutput("reveal_busy", 1'b1, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      pulseTick();
      checkPix($sformatf("reveal_t%0d", t), 10'd259, 10'd230, t / 4);
    end
    repeat (19) pulseTick();
  endtask

`ifdef CHAR_SEQ_BLINK_EN
  task automatic test_blink();
    pulseTick();
    checkOutput("blink_t32", 1'b1, 1'b0);
    checkPix("blink_t32_vis", 10'd259, 10'd230, 8);
    repeat (14) pulseTick();
    checkPix("blink_t46_vis", 10'd259, 10'd230, 8);
    pulseTick();
    checkPix("blink_t47_off", 10'd259, 10'd230, 0);
    repeat (14) pulseTick();
    checkPix("blink_t61_off", 10'd259, 10'd230, 0);
    pulseTick();
    checkPix("blink_t62_on", 10'd259, 10'd230, 8);
    repeat (59) pulseTick();
    checkOutput("blink_t121", 1'b1, 1'b0);
    pulseTick();
    checkOutput("blink_done", 1'b0, 1'b1);
    checkPix("show_vis", 10'd259, 10'd230, 8);
    checkOutput("done_one_cycle", 1'b0, 1'b0);
    repeat (20) pulseTick();
    checkPix("show_steady", 10'd259, 10'd230, 8);
  endtask
`else
  task automatic test_no_blink();
    pulseTick();
    checkOutput("noblink_done", 1'b0, 1'b1);
    checkPix("show_vis", 10'd259, 10'd230, 8);
    checkOutput("done_one_cycle", 1'b0, 1'b0);
    repeat (20) pulseTick();
    checkPix("show_steady", 10'd259, 10'd230, 8);
  endtask
`endif

  task automatic test_gap_blank();
    checkPix("gap", 10'd218, 10'd230, 8);
    checkPix("blank_slot", 10'd293, 10'd230, 8);
    checkPix("below_row", 10'd259, 10'd260, 8);
    checkPix("last_row", 10'd259, 10'd259, 8);
    checkPix("above_row", 10'd259, 10'd219, 8);
    checkPix("first_pixel", 10'd192, 10'd220, 8);
    checkPix("left_of_base", 10'd191, 10'd230, 8);
    checkPix("last_glyph_col", 10'd441, 10'd230, 8);
    checkPix("past_end", 10'd448, 10'd230, 8);
  endtask

  task automatic test_priority();
    bus.x = 10'd259; bus.y = 10'd230;
    applyStimulus(curText, 1'b0, 1'b1);
    checkOutput("clear_wins", 1'b0, 1'b0);
    checkPix("clear_wins_pix", 10'd259, 10'd230, 0);
    bus.x = 10'd200;
    applyStimulus(curText, 1'b1, 1'b0);
    checkOutput("start_tick_busy", 1'b1, 1'b0);
    repeat (3) pulseTick();
    checkPix("start_tick_t3", 10'd200, 10'd230, 0);
    pulseTick();
    checkPix("start_tick_t4", 10'd200, 10'd230, 1);
  endtask

  task automatic test_reset_mid();
    applyStimulus(curText, 1'b0, 1'b0);
    repeat (9) pulseTick();
    checkPix("pre_reset_vis", 10'd200, 10'd230, 2);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("reset_mid");
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      pulseTick();
      if (k % 10 == 0) begin
        checkPix($sformatf("post_reset_k%0d", k), 10'd200, 10'd230, 0);
        checkOutput($sformatf("post_reset_flags_k%0d", k), 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.clear = 1'b0;
    bus.text = '0; bus.x = '0; bus.y = '0;
    test_reset();
    test_reveal();
`ifdef CHAR_SEQ_BLINK_EN
    test_blink();
`else
    test_no_blink();
`endif
    test_gap_blank();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_seq_ctrl.md
# char_seq_ctrl

Sequencer for the on-screen text banner (e.g. "SCORE", "GAME OVER") built from the shared combinational character glyph renderers. Every clock it decodes the current pixel (x, y) into a banner character cell. It drives the shared renderer inputs (start_x, start_y, glyph select), registered and aligned with the pixel. A frame-tick-driven state machine reveals the string one character at a time, optionally blinks it, and then holds it steady.

## Interface
- BASE_X, 192: left edge of character 0, in pixels.
- BASE_Y, 220: top edge of the banner row.
- NUM_CHARS, 8: character slots, 1..16. Cell pitch is fixed at 32 px, glyph width at 26 px, glyph height at 40 px.
- REVEAL_FRAMES, 4: frames per revealed character, ≥1.
- BLINK_FRAMES, 15: frames per blink half-period, ≥1.
- BLINK_COUNT, 3: number of on/off blink pairs, ≥1.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- start  in  1  one-cycle pulse; latches `text` and begins the reveal.
- clear  in  1  one-cycle pulse; banner off, return to IDLE.
- text  in  4*NUM_CHARS  glyph codes, slot i at bits [4i+3:4i]; code 0 = blank.
- x, y  in  10 each  current pixel coordinates.
- start_x, start_y  out  10 each  registered origin of the active cell.
- x_o, y_o  out  10 each  x, y delayed one cycle, aligned with start_x/start_y.
- glyph_sel  out  4  registered glyph code of the active cell; 0 when pixel_en=0.
- pixel_en  out  1  registered; the renderer output selected by glyph_sel is valid.
- busy  out  1  high in REVEAL or BLINK.
- done  out  1  one-cycle pulse on entry to SHOW.

## Operation
- States:
  - IDLE: nothing shown.
  - REVEAL: characters appear one at a time.
  - BLINK: whole string toggles on and off.
  - SHOW: whole string shown steadily.
- Registers:
  - text_q: latched copy of `text`.
  - rev: 0..NUM_CHARS, number of characters revealed.
  - fcnt: frame counter.
  - bcnt: 0..2*BLINK_COUNT, blink toggle counter.
  - blink_on: current blink phase.
- start, from any state: text_q←text, rev←0, fcnt←0, enter REVEAL.
- clear, from any state: enter IDLE. If clear and start arrive in the same cycle, clear wins.
- REVEAL, on frame_tick:
  - If fcnt==REVEAL_FRAMES-1: fcnt←0 and rev←rev+1. Otherwise fcnt←fcnt+1.
  - When rev reaches NUM_CHARS, enter BLINK with blink_on←1, fcnt←0, bcnt←0.
- BLINK, on frame_tick:
  - If fcnt==BLINK_FRAMES-1: fcnt←0, blink_on toggles, bcnt←bcnt+1.
  - When bcnt reaches 2*BLINK_COUNT, enter SHOW and pulse done.
- SHOW: holds until start or clear.
- A start coinciding with frame_tick takes priority; that tick is discarded.
- Cell decode, per cycle:
  - row_hit = BASE_Y ≤ y < BASE_Y+40.
  - off = x−BASE_X (10-bit); col_hit = BASE_X ≤ x < BASE_X+32*NUM_CHARS.
  - idx = off[9:5]; in_glyph = off[4:0] < 26. Pixels in the 6-px gaps never enable.
- Visibility of slot idx: (REVEAL and idx<rev) or (BLINK and blink_on) or SHOW.
- pixel_en = row_hit & col_hit & in_glyph & visible & (code≠0).
- start_x = BASE_X + 32*idx and start_y = BASE_Y, valid whenever pixel_en=1.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - rev, fcnt, bcnt, blink_on, text_q all 0.
- Pixel path latency is exactly 1 cycle: x, y at cycle n → all pixel outputs at n+1.
- State changes take effect 1 cycle after the start, clear or frame_tick edge.
- The pixel path uses the state as registered before that edge.
- done is high for exactly one cycle.
- busy falls in the same cycle that done rises.
- Reset asserted mid-reveal clears immediately, asynchronously. Nothing is shown until a new start.
- With defaults, REVEAL takes 32 frame_ticks and BLINK takes 90 frame_ticks.

## Configuration
- CHAR_SEQ_BLINK_EN defined: BLINK state, bcnt and blink_on are present, as described above.
- CHAR_SEQ_BLINK_EN undefined: REVEAL goes directly to SHOW on the tick that brings rev to NUM_CHARS. done pulses at that point. BLINK_FRAMES and BLINK_COUNT are ignored.

## Test plan
- Reveal timing: start with text slot2=3, then hold x=259, y=230.
  - pixel_en=0 through the 11th frame_tick.
  - After the 12th tick: pixel_en=1, glyph_sel=3, start_x=256, start_y=220, x_o=259.
- Gap and blank:
  - In SHOW, x=218, y=230 → pixel_en=0.
  - A slot with code 0 → pixel_en=0 and glyph_sel=0.
  - y=260 → pixel_en=0.
- Blink (macro defined):
  - After 32 ticks, busy=1 and the string is visible.
  - The string is invisible after tick 47 and visible again after tick 62.
  - After tick 122: done pulses for 1 cycle, busy=0, steady display.
- No-blink build (macro undefined): done pulses after tick 32, and SHOW is steady.
- Priority:
  - clear and start in the same cycle → IDLE, pixel_en=0.
  - start together with frame_tick → rev=0, fcnt=0.
- Reset mid-operation: rst_n low at tick 10 → all outputs 0 within that cycle. After release, frame_ticks alone cause no display.
